// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between the SPI arbiter, its clients and the shared spi_master.
// The slave modport is the arbiter's view; master is the environment's.
interface spi_bus_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ*19-1:0]         req_cfg;
    logic [NUM_REQ-1:0]            tx_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] tx_data;
    logic [NUM_REQ-1:0]            tx_ready;
    logic [NUM_REQ-1:0]            rx_valid;
    logic [DATA_WIDTH-1:0]         rx_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;
    logic                          m_wr_en;
    logic [DATA_WIDTH-1:0]         m_wr_data;
    logic                          m_full;
    logic                          m_done;
    logic [DATA_WIDTH-1:0]         m_rd_data;
    logic [15:0]                   m_clk_div;
    logic                          m_cpol;
    logic                          m_cpha;
    logic                          m_lsb_first;

    modport slave (
        input  req, req_len, req_cfg, tx_valid, tx_data,
        input  m_full, m_done, m_rd_data,
        output tx_ready, rx_valid, rx_data, gnt, busy,
        output m_wr_en, m_wr_data,
        output m_clk_div, m_cpol, m_cpha, m_lsb_first
    );

    modport master (
        output req, req_len, req_cfg, tx_valid, tx_data,
        output m_full, m_done, m_rd_data,
        input  tx_ready, rx_valid, rx_data, gnt, busy,
        input  m_wr_en, m_wr_data,
        input  m_clk_div, m_cpol, m_cpha, m_lsb_first
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ clients.
// A grant covers a whole burst: config, TX forwarding and RX routing.
module spi_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_bus_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 19;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] OWN_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] OWN_LAST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CFG_RST = {16'd2, 3'b000};

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        PUSH,
        DRAIN,
        RELEASE
    } state_t;

    state_t                  state;
    logic [IW-1:0]           owner;
    logic [IW-1:0]           rr_ptr;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    pushed;
    logic [LEN_WIDTH-1:0]    rcvd;
    logic [CW-1:0]           cfg_q;
    logic [NUM_REQ-1:0]      rx_valid_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;

    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_found;
    logic [IW-1:0]           pick_idx;
    logic [LEN_WIDTH-1:0]    pick_len;
    logic [CW-1:0]           pick_cfg;
    logic [NUM_REQ-1:0]      owner_oh;
    logic                    own_valid;
    logic [DATA_WIDTH-1:0]   own_data;
    logic                    can_push;
    logic                    accept;
    logic                    owning;
    logic                    rx_window;

    // Eligibility: a level request with a non-zero burst length.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req[i] &&
                (bus.req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
        end
    end

    // Round-robin pick: first eligible index at or above rr_ptr, else wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_len   = '0;
        pick_cfg   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && eligible[i] && (IW'(i) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
                pick_len   = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
                pick_cfg   = bus.req_cfg[i*CW +: CW];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && eligible[i]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
                pick_len   = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
                pick_cfg   = bus.req_cfg[i*CW +: CW];
            end
        end
    end

    // Select the owner's TX lane and build its one-hot mask.
    always_comb begin
        owner_oh  = '0;
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                owner_oh[i] = 1'b1;
                own_valid   = bus.tx_valid[i];
                own_data    = bus.tx_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // TX path is combinational so m_full back-pressures in the same cycle.
    always_comb begin
        owning    = (state == GRANT) || (state == PUSH) ||
                    (state == DRAIN);
        rx_window = (state == PUSH) || (state == DRAIN);
        can_push  = (state == PUSH) && !bus.m_full && (pushed < len_q);
        accept    = can_push && own_valid;
    end

    assign bus.tx_ready    = can_push ? owner_oh : '0;
    assign bus.m_wr_en     = accept;
    assign bus.m_wr_data   = (state == PUSH) ? own_data : '0;
    assign bus.gnt         = owning ? owner_oh : '0;
    assign bus.busy        = (state != IDLE);
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.m_clk_div   = cfg_q[18:3];
    assign bus.m_cpol      = cfg_q[2];
    assign bus.m_cpha      = cfg_q[1];
    assign bus.m_lsb_first = cfg_q[0];

    // Burst sequencer: owner/len/cfg latch, byte counters, RX routing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            len_q      <= '0;
            pushed     <= '0;
            rcvd       <= '0;
            cfg_q      <= CFG_RST;
            rx_valid_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= '0;
            if (rx_window && bus.m_done) begin
                rx_valid_q <= owner_oh;
                rx_data_q  <= bus.m_rd_data;
                rcvd       <= rcvd + LEN_ONE;
            end
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner <= pick_idx;
                        len_q <= pick_len;
                        cfg_q <= pick_cfg;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    pushed <= '0;
                    rcvd   <= '0;
                    state  <= PUSH;
                end
                PUSH: begin
                    if (accept) begin
                        pushed <= pushed + LEN_ONE;
                        if (pushed + LEN_ONE == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rcvd == len_q) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    rr_ptr <= (owner == OWN_LAST) ? '0 : owner + OWN_ONE;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
